// File: rtl/pmem_arbiter_pkg.sv
// Shared types and default widths for the physical-memory arbiter.
// Cache line widths and the burst FSM state encoding live here.
package mem_arb_pkg;

    localparam int LINE_W_DEF = 256;
    localparam int BEAT_W_DEF = 64;
    localparam int ADDR_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        RBURST,
        WBURST,
        RESP
    } arb_state_t;

    function automatic int beats_per_line(input int line_w, input int beat_w);
        return line_w / beat_w;
    endfunction

endpackage

// File: rtl/pmem_arbiter_if.sv
// Cache-side request bundle plus the physical-memory burst bus.
// slave is the arbiter's view; master is the requester/memory side.
interface pmem_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int LINE_W    = 256,
    parameter int BEAT_W    = 64,
    parameter int ADDR_W    = 32
);

    logic [NUM_PORTS-1:0]             req_read;
    logic [NUM_PORTS-1:0]             req_write;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_PORTS-1:0][LINE_W-1:0] req_wdata;
    logic [LINE_W-1:0]                req_rdata;
    logic [NUM_PORTS-1:0]             req_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  req_read, req_write, req_addr, req_wdata,
        input  pmem_rdata, pmem_resp,
        output req_rdata, req_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output req_read, req_write, req_addr, req_wdata,
        output pmem_rdata, pmem_resp,
        input  req_rdata, req_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/pmem_arbiter_rr_arbiter.sv
// Round-robin grant: first pending port after last_grant, wrapping.
// Purely combinational; the caller registers the chosen index.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_pending,
    input  logic [IDX_W-1:0]     i_last_grant,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic                 o_valid
);

    always_comb begin
        int w_j;
        w_j     = 0;
        o_grant = '0;
        o_valid = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_j = int'(i_last_grant) + k;
            if (w_j >= NUM_PORTS) w_j = w_j - NUM_PORTS;
            if (!o_valid && i_pending[w_j]) begin
                o_grant[w_j] = 1'b1;
                o_valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Multi-port cacheline arbiter in front of a beat-serial burst memory.
// One line transfer in flight at a time; grant rotates round-robin.
module pmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int LINE_W    = LINE_W_DEF,
    parameter int BEAT_W    = BEAT_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    pmem_arbiter_if.slave bus
);

    localparam int BEATS   = beats_per_line(LINE_W, BEAT_W);
    localparam int BEAT_IW = $clog2(BEATS);
    localparam int IDX_W   = $clog2(NUM_PORTS);
    localparam int OFF_W   = $clog2(LINE_W / 8);

    localparam logic [ADDR_W-1:0]  ADDR_MASK = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [BEAT_IW-1:0] LAST_BEAT = BEAT_IW'(BEATS - 1);
    localparam logic [NUM_PORTS-1:0] ONE_HOT0 = NUM_PORTS'(1);

    arb_state_t           r_state;
    logic [BEAT_IW-1:0]   r_beat;
    logic [IDX_W-1:0]     r_grant;
    logic [IDX_W-1:0]     r_last;
    logic [ADDR_W-1:0]    r_addr;
    logic [LINE_W-1:0]    r_wline;
    logic [LINE_W-1:0]    r_rline;
    logic [LINE_W-1:0]    r_rdata;
    logic [NUM_PORTS-1:0] r_resp;
    logic                 r_pmem_read;
    logic                 r_pmem_write;

    logic [NUM_PORTS-1:0] w_pending;
    logic [NUM_PORTS-1:0] w_gnt_oh;
    logic                 w_gnt_valid;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic [LINE_W-1:0]    w_line_next;
    logic                 w_last;

    assign w_pending = bus.req_read | bus.req_write;
    assign w_last    = (r_beat == LAST_BEAT);

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr (
        .i_pending    (w_pending),
        .i_last_grant (r_last),
        .o_grant      (w_gnt_oh),
        .o_valid      (w_gnt_valid)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_gnt_oh[i]) w_gnt_idx = IDX_W'(i);
        end
    end

    // Incoming read beat merged into the line being assembled.
    always_comb begin
        w_line_next = r_rline;
        w_line_next[int'(r_beat)*BEAT_W +: BEAT_W] = bus.pmem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_beat       <= '0;
            r_grant      <= '0;
            r_last       <= IDX_W'(NUM_PORTS - 1);
            r_addr       <= '0;
            r_wline      <= '0;
            r_rline      <= '0;
            r_rdata      <= '0;
            r_resp       <= '0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
        end else begin
            r_resp <= '0;
            unique case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_grant <= w_gnt_idx;
                        r_addr  <= bus.req_addr[w_gnt_idx] & ADDR_MASK;
                        r_wline <= bus.req_wdata[w_gnt_idx];
                        r_beat  <= '0;
                        // Read+write together counts as a write.
                        if (bus.req_write[w_gnt_idx]) begin
                            r_state      <= WBURST;
                            r_pmem_write <= 1'b1;
                        end else begin
                            r_state     <= RBURST;
                            r_pmem_read <= 1'b1;
                        end
                    end
                end
                RBURST: begin
                    if (bus.pmem_resp) begin
                        r_rline <= w_line_next;
                        if (w_last) begin
                            r_rdata     <= w_line_next;
                            r_beat      <= '0;
                            r_pmem_read <= 1'b0;
                            r_resp      <= ONE_HOT0 << r_grant;
                            r_state     <= RESP;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                WBURST: begin
                    if (bus.pmem_resp) begin
                        if (w_last) begin
                            r_beat       <= '0;
                            r_pmem_write <= 1'b0;
                            r_resp       <= ONE_HOT0 << r_grant;
                            r_state      <= RESP;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                RESP: begin
                    r_last  <= r_grant;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_rdata    = r_rdata;
    assign bus.req_resp     = r_resp;
    assign bus.pmem_read    = r_pmem_read;
    assign bus.pmem_write   = r_pmem_write;
    assign bus.pmem_address = r_addr;
    assign bus.pmem_wdata   = (r_state == WBURST)
                            ? r_wline[int'(r_beat)*BEAT_W +: BEAT_W]
                            : '0;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench: 2-port arbiter for directed traffic, 4-port for rotation.
// Stimulus pushes expectations; negedge monitors pop and compare.
module tb_pmem_arbiter;

    localparam int LW = 256;
    localparam int BW = 64;
    localparam int AW = 32;
    localparam int NB = LW / BW;

    typedef struct {
        int            port;
        bit            wr;
        logic [LW-1:0] line;
        logic [AW-1:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pmem_arbiter_if #(.NUM_PORTS(2), .LINE_W(LW), .BEAT_W(BW), .ADDR_W(AW)) bus2();
    pmem_arbiter_if #(.NUM_PORTS(4), .LINE_W(LW), .BEAT_W(BW), .ADDR_W(AW)) bus4();

    pmem_arbiter #(.NUM_PORTS(2), .LINE_W(LW), .BEAT_W(BW), .ADDR_W(AW)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    pmem_arbiter #(.NUM_PORTS(4), .LINE_W(LW), .BEAT_W(BW), .ADDR_W(AW)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    int checks = 0;
    int errors = 0;

    exp_t          exp_q[$];
    logic [BW-1:0] beat_q[$];
    int            exp4_q[$];
    logic [BW-1:0] rbeats[NB];
    int            stall_n = 0;
    logic [AW-1:0] addr_tab[2][2];

    task automatic check(input string nm, input logic [LW-1:0] act,
                         input logic [LW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    function automatic logic [LW-1:0] rd_line();
        logic [LW-1:0] l;
        for (int i = 0; i < NB; i++) l[i*BW +: BW] = rbeats[i];
        return l;
    endfunction

    task automatic push_rd(input int p, input logic [AW-1:0] a);
        exp_t e;
        e.port = p; e.wr = 1'b0; e.line = rd_line(); e.addr = a;
        exp_q.push_back(e);
    endtask

    task automatic push_wr(input int p, input logic [AW-1:0] a,
                           input logic [LW-1:0] l);
        exp_t e;
        e.port = p; e.wr = 1'b1; e.line = l; e.addr = a;
        exp_q.push_back(e);
        for (int i = 0; i < NB; i++) beat_q.push_back(l[i*BW +: BW]);
    endtask

    // Memory model for the 2-port DUT: optional stall before every beat.
    initial begin
        int cnt;
        int wc;
        cnt = 0;
        wc  = 0;
        bus2.pmem_resp  = 1'b0;
        bus2.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !(bus2.pmem_read || bus2.pmem_write)) begin
                cnt = 0;
                wc  = stall_n;
                bus2.pmem_resp = 1'b0;
            end else begin
                if (bus2.pmem_resp) begin
                    cnt = (cnt + 1) % NB;
                    wc  = stall_n;
                end
                if (wc > 0) begin
                    wc--;
                    bus2.pmem_resp = 1'b0;
                end else begin
                    bus2.pmem_resp  = 1'b1;
                    bus2.pmem_rdata = rbeats[cnt];
                end
            end
        end
    end

    initial begin
        bus4.pmem_resp  = 1'b0;
        bus4.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus4.pmem_resp = !rst && (bus4.pmem_read || bus4.pmem_write);
        end
    end

    // Monitor for the 2-port DUT.
    initial begin
        exp_t          e;
        bit            burst_on;
        bit            burst_wr;
        logic [AW-1:0] burst_addr;
        burst_on   = 1'b0;
        burst_wr   = 1'b0;
        burst_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                burst_on = 1'b0;
            end else begin
                if (!$onehot0(bus2.req_resp)) begin
                    checks++; errors++;
                    $display("FAIL resp2_onehot: got %b", bus2.req_resp);
                end
                if (bus2.pmem_read || bus2.pmem_write) begin
                    if (!burst_on) begin
                        burst_on   = 1'b1;
                        burst_wr   = bus2.pmem_write;
                        burst_addr = bus2.pmem_address;
                    end else if (bus2.pmem_address !== burst_addr) begin
                        checks++; errors++;
                        $display("FAIL addr_stable: got %h want %h",
                                 bus2.pmem_address, burst_addr);
                    end
                end else begin
                    burst_on = 1'b0;
                end
                if (bus2.pmem_write && bus2.pmem_resp) begin
                    if (beat_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wbeat_extra: got %h want none", bus2.pmem_wdata);
                    end else begin
                        check("wbeat", bus2.pmem_wdata, beat_q.pop_front());
                    end
                end
                if (bus2.req_resp != '0) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL resp_extra: got %b want none", bus2.req_resp);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_vec", bus2.req_resp, LW'(1) << e.port);
                        check("burst_addr", burst_addr, e.addr);
                        check("burst_op", burst_wr, e.wr);
                        if (!e.wr) check("rdata", bus2.req_rdata, e.line);
                    end
                end
            end
        end
    end

    // Monitor for the 4-port DUT.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (!$onehot0(bus4.req_resp)) begin
                    checks++; errors++;
                    $display("FAIL resp4_onehot: got %b", bus4.req_resp);
                end
                if (bus4.req_resp != '0) begin
                    if (exp4_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL resp4_extra: got %b want none", bus4.req_resp);
                    end else begin
                        check("resp4_vec", bus4.req_resp, LW'(1) << exp4_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic do_one(input int p, input bit rd, input bit wr,
                          input logic [AW-1:0] a, input logic [LW-1:0] l,
                          output int n);
        bus2.req_read[p]  = rd;
        bus2.req_write[p] = wr;
        bus2.req_addr[p]  = a;
        bus2.req_wdata[p] = l;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus2.req_resp[p] && n < 200);
        check("resp_seen", bus2.req_resp[p], 1'b1);
        bus2.req_read[p]  = 1'b0;
        bus2.req_write[p] = 1'b0;
    endtask

    task automatic serve2(input int want0, input int want1);
        int want[2];
        int done[2];
        int n;
        want[0] = want0; want[1] = want1;
        done[0] = 0;     done[1] = 0;
        n = 0;
        for (int p = 0; p < 2; p++) begin
            if (want[p] > 0) begin
                bus2.req_read[p] = 1'b1;
                bus2.req_addr[p] = addr_tab[p][0];
            end
        end
        while ((done[0] < want[0] || done[1] < want[1]) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
            for (int p = 0; p < 2; p++) begin
                if (bus2.req_resp[p]) begin
                    done[p]++;
                    if (done[p] < want[p]) bus2.req_addr[p] = addr_tab[p][done[p]];
                    else bus2.req_read[p] = 1'b0;
                end
            end
        end
        check("serve2_done", done[0] + done[1], want0 + want1);
    endtask

    initial begin
        int            n;
        int            k;
        int            d4[4];
        logic [LW-1:0] line1;
        logic [LW-1:0] wl;

        bus2.req_read  = '0;
        bus2.req_write = '0;
        bus2.req_addr  = '0;
        bus2.req_wdata = '0;
        bus4.req_read  = '0;
        bus4.req_write = '0;
        bus4.req_addr  = '0;
        bus4.req_wdata = '0;
        rbeats[0] = 64'h1111_1111_1111_1111;
        rbeats[1] = 64'h2222_2222_2222_2222;
        rbeats[2] = 64'h3333_3333_3333_3333;
        rbeats[3] = 64'h4444_4444_4444_4444;

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp", bus2.req_resp, '0);
        check("rst_pread", bus2.pmem_read, 1'b0);
        check("rst_pwrite", bus2.pmem_write, 1'b0);
        check("rst_rdata", bus2.req_rdata, '0);
        check("rst_addr", bus2.pmem_address, '0);
        check("rst_wdata", bus2.pmem_wdata, '0);
        check("rst_resp4", bus4.req_resp, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single read, minimum latency.
        push_rd(0, 32'h0000_1220);
        line1 = rd_line();
        do_one(0, 1'b1, 1'b0, 32'h0000_1234, '0, n);
        check("rd_latency", n + 1, NB + 2);
        check("rd_line_out", bus2.req_rdata, line1);
        check("pread_low_resp", bus2.pmem_read, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Read and write together behaves as a write.
        wl = {64'h4, 64'h3, 64'h2, 64'h1};
        push_wr(0, 32'h0000_2000, wl);
        do_one(0, 1'b1, 1'b1, 32'h0000_2010, wl, n);
        repeat (2) @(posedge clk);
        #1;

        // Port 1 write, beats in ascending order.
        wl = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        push_wr(1, 32'h8000_0040, wl);
        do_one(1, 1'b0, 1'b1, 32'h8000_0040, wl, n);
        check("rdata_held", bus2.req_rdata, line1);
        repeat (2) @(posedge clk);
        #1;

        // Both ports held: service alternates 0,1,0,1.
        addr_tab[0][0] = 32'h100; addr_tab[0][1] = 32'h300;
        addr_tab[1][0] = 32'h200; addr_tab[1][1] = 32'h400;
        push_rd(0, 32'h100);
        push_rd(1, 32'h200);
        push_rd(0, 32'h300);
        push_rd(1, 32'h400);
        serve2(2, 2);
        repeat (2) @(posedge clk);
        #1;

        // Stalled memory between beats.
        rbeats[0] = 64'hA1A1_0000_0000_0001;
        rbeats[1] = 64'hB2B2_0000_0000_0002;
        rbeats[2] = 64'hC3C3_0000_0000_0003;
        rbeats[3] = 64'hD4D4_0000_0000_0004;
        stall_n = 3;
        push_rd(1, 32'h0000_0040);
        do_one(1, 1'b1, 1'b0, 32'h0000_0047, '0, n);
        check("stall_latency_min", n >= 4 * NB + 1, 1'b1);
        stall_n = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a read burst.
        bus2.req_read[1] = 1'b1;
        bus2.req_addr[1] = 32'h0000_3000;
        k = 0;
        n = 0;
        while (k < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (bus2.pmem_read && bus2.pmem_resp) k++;
        end
        check("rst_setup_beats", k, 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_pread", bus2.pmem_read, 1'b0);
        check("rst_mid_resp", bus2.req_resp, '0);
        check("rst_mid_addr", bus2.pmem_address, '0);
        bus2.req_read = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        addr_tab[0][0] = 32'h500; addr_tab[0][1] = 32'h500;
        addr_tab[1][0] = 32'h600; addr_tab[1][1] = 32'h600;
        push_rd(0, 32'h500);
        push_rd(1, 32'h600);
        serve2(1, 1);
        repeat (2) @(posedge clk);
        #1;

        // Four ports all pending: 0,1,2,3 then port 0 again.
        exp4_q.push_back(0);
        exp4_q.push_back(1);
        exp4_q.push_back(2);
        exp4_q.push_back(3);
        exp4_q.push_back(0);
        for (int p = 0; p < 4; p++) d4[p] = 0;
        bus4.req_read = 4'hF;
        n = 0;
        while ((d4[0] + d4[1] + d4[2] + d4[3]) < 5 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
            for (int p = 0; p < 4; p++) begin
                if (bus4.req_resp[p]) begin
                    d4[p]++;
                    if (p != 0 || d4[0] == 2) bus4.req_read[p] = 1'b0;
                end
            end
        end
        check("four_done", d4[0] + d4[1] + d4[2] + d4[3], 5);
        bus4.req_read = '0;

        repeat (5) @(posedge clk);
        #1;
        check("exp_q_empty", exp_q.size(), 0);
        check("beat_q_empty", beat_q.size(), 0);
        check("exp4_q_empty", exp4_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 Parameter NUM_PORTS, 2, number of cache-side requesters (>=2).
REQ-002 Parameter LINE_W, 256, cacheline width in bits.
REQ-003 Parameter BEAT_W, 64, physical-memory burst beat width; LINE_W/BEAT_W = BEATS (power of 2).
REQ-004 Parameter ADDR_W, 32, address width.
REQ-005 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  system clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 req_read  input  NUM_PORTS  per-port line read request.
REQ-009 req_write  input  NUM_PORTS  per-port line write request.
REQ-010 req_addr  input  NUM_PORTS x ADDR_W  per-port byte address.
REQ-011 req_wdata  input  NUM_PORTS x LINE_W  per-port write line.
REQ-012 req_rdata  output  LINE_W  read line, shared by all ports.
REQ-013 req_resp  output  NUM_PORTS  one-hot per-port completion.
REQ-014 pmem_read  output  1  burst read request.
REQ-015 pmem_write  output  1  burst write request.
REQ-016 pmem_address  output  ADDR_W  line-aligned burst address.
REQ-017 pmem_wdata  output  BEAT_W  current write beat.
REQ-018 pmem_rdata  input  BEAT_W  current read beat.
REQ-019 pmem_resp  input  1  beat accepted/valid.

Function
REQ-020 FSM states SHALL be IDLE, RBURST, WBURST, RESP.
REQ-021 IDLE: a port is pending when req_read or req_write is high; the arbiter SHALL grant the first pending port searching round-robin from last_grant+1 (mod NUM_PORTS).
REQ-022 On grant, the block SHALL latch port index, op, req_addr with low log2(LINE_W/8) bits zeroed, and req_wdata; next state RBURST or WBURST.
REQ-023 A port asserting both req_read and req_write SHALL be treated as a write.
REQ-024 RBURST: pmem_read held high; each cycle with pmem_resp, pmem_rdata SHALL be stored into line slice [beat*BEAT_W +: BEAT_W] and beat incremented.
REQ-025 WBURST: pmem_write held high; pmem_wdata SHALL equal latched line slice [beat*BEAT_W +: BEAT_W]; beat increments on pmem_resp.
REQ-026 On pmem_resp with beat = BEATS-1, beat SHALL wrap to 0 and state go to RESP; pmem_read/pmem_write SHALL be low the following cycle.
REQ-027 RESP: req_resp[grant] SHALL be high for exactly one cycle, req_rdata valid that cycle (last read line held otherwise); then IDLE; last_grant <= grant.
REQ-028 Minimum request-to-resp latency SHALL be BEATS+2 cycles with pmem_resp high every cycle.
REQ-029 pmem_address SHALL be stable for the entire burst; requests from other ports during a burst SHALL wait without being dropped.
REQ-030 Requesters SHALL hold request and operands until req_resp; a request withdrawn before grant is ignored.
REQ-031 At most one req_resp bit SHALL ever be high; no beat SHALL be accepted outside RBURST/WBURST.

Reset
REQ-032 rst SHALL force, asynchronously: state IDLE, beat 0, last_grant NUM_PORTS-1 (port 0 wins first), line buffer 0, all outputs 0.
REQ-033 Reset mid-burst SHALL abort the burst with no req_resp; post-reset arbitration restarts at port 0.

Structure
REQ-034 Package mem_arb_pkg SHALL hold arb_state_t and the default LINE_W/BEAT_W/ADDR_W constants.
REQ-035 Grant selection SHALL live in sub-module rr_arbiter (NUM_PORTS, pending vector, last_grant -> one-hot grant, valid).

Verification
REQ-036 Port0 read 0x0000_1234, pmem_rdata beats 0x11..,0x22..,0x33..,0x44.. -> pmem_address 0x0000_1220, req_rdata {0x44..,0x33..,0x22..,0x11..}, req_resp[0] at cycle 6.
REQ-037 Port1 write 0x8000_0040 line 0xDDDD..CCCC..BBBB..AAAA.. -> pmem_wdata AAAA..,BBBB..,CCCC..,DDDD.. in order, req_resp=2'b10 once.
REQ-038 Ports 0 and 1 request simultaneously, held -> service order 0,1,0,1 across four requests.
REQ-039 pmem_resp stalls 3 cycles between beats -> beat count and pmem_address unchanged during stalls; correct line returned.
REQ-040 rst asserted after beat 2 of a read -> no req_resp, pmem_read low immediately; next request granted to port 0.
REQ-041 NUM_PORTS=4, all pending -> grants 0,1,2,3,0; exactly one req_resp bit ever high.
